cpu_write_sbuf: RTL and testbench
=================================

// Module: cpu_write_sbuf
// PURPOSE
//   Writeback unit with a parametrised store buffer. Register writeback is
//   registered one cycle; stores pass through a DEPTH-entry FIFO to a
//   valid/ack memory port with byte/half/word sizing and byte lane enables
//   (big-endian). Sits between the execute stage and the register file / data
//   memory port. Raises stall_o upstream when the buffer is full.
// PARAMETERS
//   DEPTH      4   store buffer entries; power of 2, >= 2
//   ADDR_W     32  address width, >= 3
//   REG_IDX_W  4   register index width
// PORTS
//   clk_i                   in   1          clock, rising edge
//   rst_i                   in   1          reset, asynchronous, active-low
//   valid_i                 in   1          instruction present at writeback
//   register_write_index_i  in   REG_IDX_W  destination register
//   register_write_enable_i in   1          instruction writes a register
//   memory_write_enable_i   in   1          instruction is a store
//   memory_write_size_i     in   2          00 byte, 01 half, 10/11 word
//   memory_write_address_i  in   ADDR_W     store byte address
//   result_i                in   32         ALU result / store data (LSB-aligned)
//   stall_o                 out  1          buffer full; upstream holds instruction
//   register_write_index_o  out  REG_IDX_W  registered index
//   register_write_enable_o out  1          registered write enable
//   result_o                out  32         registered result
//   mem_req_o               out  1          head entry valid
//   mem_ack_i               in   1          memory accepts head this cycle
//   mem_addr_o              out  ADDR_W     word-aligned address of head
//   mem_data_o              out  32         lane-replicated store data of head
//   mem_sel_o               out  4          byte enables; bit3 = bits[31:24]
//   buffer_count_o          out  clog2(DEPTH)+1  occupied entries
//   empty_o                 out  1          no pending stores (fence/drain)
// BEHAVIOUR
//   - Reset (rst_i=0, async): all outputs 0 except empty_o=1; pointers and
//     count cleared; pending stores discarded, including mid-handshake.
//   - accept = valid_i & ~stall_o. stall_o = (count==DEPTH), from registers
//     only (no combinational path from mem_ack_i). Stall applies to every
//     instruction; upstream re-presents it unchanged.
//   - Reg path: at each edge, index/result_o <= inputs;
//     register_write_enable_o <= accept & register_write_enable_i.
//   - Push when accept & memory_write_enable_i. Entry stores addr, sel, data:
//     byte: sel = 4'b1000 >> addr[1:0]; data = {4{result_i[7:0]}}
//     half: sel = addr[1] ? 4'b0011 : 4'b1100; data = {2{result_i[15:0]}};
//           addr[0] ignored
//     word: sel = 4'b1111; data = result_i; addr[1:0] ignored
//     mem_addr_o = {addr[ADDR_W-1:2], 2'b00}.
//   - mem_req_o = ~empty; head fields driven from buffer registers. They are
//     stable while mem_req_o & ~mem_ack_i. Pop on mem_req_o & mem_ack_i.
//     mem_ack_i is ignored when empty.
//   - Latency: a store pushed at edge N into an empty buffer shows
//     mem_req_o=1 in cycle N+1. No bypass. Strict FIFO order.
//   - Simultaneous push & pop: count unchanged, both pointers advance.
//     At count==DEPTH a pop frees a slot; stall_o drops the next cycle.
//   - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
//   - count is never > DEPTH and never < 0; empty_o = (count==0).
// TESTING
//   1. Push 2 stores with ack=0, then drive rst_i=0 between edges ->
//      mem_req_o=0, buffer_count_o=0, empty_o=1 immediately.
//   2. Word store, addr 0x1003, data 0xDEADBEEF, ack=1 -> next cycle
//      mem_req_o=1, addr 0x1000, sel 1111, data DEADBEEF; empty_o=1 after
//      the following edge.
//   3. Byte store, addr 0x2001, data 0xAB -> sel 0100, data ABABABAB.
//      Then half store, addr 0x2002, data 0x1234 -> sel 0011, data 12341234.
//   4. DEPTH=4, ack=0, 5 back-to-back stores -> stall_o=1 after the 4th
//      push; 5th held. One ack -> 5th accepted next cycle; drain order is
//      1..5; count peaks at 4.
//   5. count=2 with push and ack in the same cycle -> count stays 2, order
//      preserved; repeat through a pointer wrap.
//   6. valid_i=1, index 7, reg-enable=1, result 0x55 -> next cycle
//      register_write_enable_o=1, index 7, result_o 0x55. Same stimulus
//      with stall_o=1 -> register_write_enable_o=0.

Source files
------------

// File: rtl/cpu_write_sbuf.sv
// cpu_write_sbuf: writeback unit with a DEPTH-entry store buffer.
//
// Register writeback (index, enable, result) is registered for one cycle.
// Stores are converted to a word-aligned address, big-endian byte lane
// enables and lane-replicated data, then queued in a FIFO. The head of the
// FIFO is presented on a valid/ack memory port. stall_o is raised upstream
// while the FIFO is full.
//
// Ports
//   clk_i, rst_i                   clock (rising edge), async active-low reset
//   valid_i                        instruction present at writeback
//   register_write_index_i/_o      destination register (in / registered)
//   register_write_enable_i/_o     register write (in / registered, accept-gated)
//   memory_write_enable_i          instruction is a store
//   memory_write_size_i            00 byte, 01 half, 1x word
//   memory_write_address_i         store byte address
//   result_i / result_o            ALU result or store data / registered result
//   stall_o                        buffer full; upstream holds instruction
//   mem_req_o, mem_ack_i           head valid / memory accepts head
//   mem_addr_o, mem_data_o         head word address / replicated data
//   mem_sel_o                      head byte enables, bit3 = data[31:24]
//   buffer_count_o, empty_o        occupancy / no pending stores
module cpu_write_sbuf #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [REG_IDX_W-1:0]       register_write_index_i,
    input  logic                       register_write_enable_i,
    input  logic                       memory_write_enable_i,
    input  logic [1:0]                 memory_write_size_i,
    input  logic [ADDR_W-1:0]          memory_write_address_i,
    input  logic [31:0]                result_i,
    output logic                       stall_o,
    output logic [REG_IDX_W-1:0]       register_write_index_o,
    output logic                       register_write_enable_o,
    output logic [31:0]                result_o,
    output logic                       mem_req_o,
    input  logic                       mem_ack_i,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [31:0]                mem_data_o,
    output logic [3:0]                 mem_sel_o,
    output logic [$clog2(DEPTH):0]     buffer_count_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [REG_IDX_W-1:0] reg_idx_q;
    logic                 reg_we_q;
    logic [31:0]          result_q;

    logic [ADDR_W-1:0]    addr_q [DEPTH];
    logic [3:0]           sel_q  [DEPTH];
    logic [31:0]          data_q [DEPTH];

    logic [ADDR_W-1:0]    ent_addr_d;
    logic [3:0]           ent_sel_d;
    logic [31:0]          ent_data_d;

    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 push;
    logic                 pop;

    // Stall and request are purely registered: no path from mem_ack_i.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign accept = valid_i & ~full;
    assign push   = accept & memory_write_enable_i;
    assign pop    = ~empty & mem_ack_i;

    always_comb begin
        ent_addr_d = {memory_write_address_i[ADDR_W-1:2], 2'b00};
        ent_sel_d  = 4'b1111;
        ent_data_d = result_i;
        case (memory_write_size_i)
            2'b00: begin
                ent_sel_d  = 4'b1000 >> memory_write_address_i[1:0];
                ent_data_d = {4{result_i[7:0]}};
            end
            2'b01: begin
                ent_sel_d  = memory_write_address_i[1] ? 4'b0011 : 4'b1100;
                ent_data_d = {2{result_i[15:0]}};
            end
            default: begin
                ent_sel_d  = 4'b1111;
                ent_data_d = result_i;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            reg_idx_q <= '0;
            reg_we_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            reg_idx_q <= register_write_index_i;
            reg_we_q  <= accept & register_write_enable_i;
            result_q  <= result_i;
        end
    end

    // Entry storage needs no reset: it is only observed through the head
    // outputs, which are forced to zero whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= ent_addr_d;
            sel_q[wr_ptr_q]  <= ent_sel_d;
            data_q[wr_ptr_q] <= ent_data_d;
        end
    end

    assign stall_o                 = full;
    assign register_write_index_o  = reg_idx_q;
    assign register_write_enable_o = reg_we_q;
    assign result_o                = result_q;
    assign mem_req_o               = ~empty;
    assign mem_addr_o              = empty ? '0 : addr_q[rd_ptr_q];
    assign mem_sel_o               = empty ? '0 : sel_q[rd_ptr_q];
    assign mem_data_o              = empty ? '0 : data_q[rd_ptr_q];
    assign buffer_count_o          = count_q;
    assign empty_o                 = empty;

endmodule

// File: tb/tb_cpu_write_sbuf.sv
module tb_cpu_write_sbuf;

    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 32;
    localparam int REG_IDX_W = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   valid_i;
    logic [REG_IDX_W-1:0]   register_write_index_i;
    logic                   register_write_enable_i;
    logic                   memory_write_enable_i;
    logic [1:0]             memory_write_size_i;
    logic [ADDR_W-1:0]      memory_write_address_i;
    logic [31:0]            result_i;
    logic                   stall_o;
    logic [REG_IDX_W-1:0]   register_write_index_o;
    logic                   register_write_enable_o;
    logic [31:0]            result_o;
    logic                   mem_req_o;
    logic                   mem_ack_i;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [31:0]            mem_data_o;
    logic [3:0]             mem_sel_o;
    logic [$clog2(DEPTH):0] buffer_count_o;
    logic                   empty_o;

    cpu_write_sbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .valid_i                 (valid_i),
        .register_write_index_i  (register_write_index_i),
        .register_write_enable_i (register_write_enable_i),
        .memory_write_enable_i   (memory_write_enable_i),
        .memory_write_size_i     (memory_write_size_i),
        .memory_write_address_i  (memory_write_address_i),
        .result_i                (result_i),
        .stall_o                 (stall_o),
        .register_write_index_o  (register_write_index_o),
        .register_write_enable_o (register_write_enable_o),
        .result_o                (result_o),
        .mem_req_o               (mem_req_o),
        .mem_ack_i               (mem_ack_i),
        .mem_addr_o              (mem_addr_o),
        .mem_data_o              (mem_data_o),
        .mem_sel_o               (mem_sel_o),
        .buffer_count_o          (buffer_count_o),
        .empty_o                 (empty_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a queue of expected memory transactions plus the
    // expected registered writeback fields.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_idx;
    logic        m_rwe;
    logic [31:0] m_result;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[8];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic ent_t make_entry(input logic [1:0] sz, input logic [31:0] addr,
                                        input logic [31:0] data);
        ent_t e;
        int   lane;
        lane   = int'(addr % 4);
        e.addr = addr - (addr % 4);
        if (sz == 2'd0) begin
            e.sel  = 4'(8 >> lane);
            e.data = {24'd0, data[7:0]} * 32'h0101_0101;
        end else if (sz == 2'd1) begin
            e.sel  = (lane / 2 == 0) ? 4'hC : 4'h3;
            e.data = {16'd0, data[15:0]} * 32'h0001_0001;
        end else begin
            e.sel  = 4'hF;
            e.data = data;
        end
        return e;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_idx    = '0;
        m_rwe    = 1'b0;
        m_result = '0;
    endfunction

    task automatic check_all();
        chk("count",  32'(buffer_count_o), 32'(q.size()));
        chk("empty",  32'(empty_o),        32'(q.size() == 0));
        chk("stall",  32'(stall_o),        32'(q.size() == DEPTH));
        chk("req",    32'(mem_req_o),      32'(q.size() != 0));
        chk("reg_we", 32'(register_write_enable_o), 32'(m_rwe));
        chk("reg_idx", 32'(register_write_index_o), 32'(m_idx));
        chk("result", result_o, m_result);
        if (q.size() != 0) begin
            chk("head_addr", mem_addr_o, q[0].addr);
            chk("head_data", mem_data_o, q[0].data);
            chk("head_sel",  32'(mem_sel_o), 32'(q[0].sel));
        end
    endtask

    // Called just after a falling edge: apply inputs, advance the model over
    // the coming rising edge, then check at the next falling edge.
    task automatic drive(input logic v, input logic [3:0] idx, input logic rwe,
                         input logic mwe, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] data, input logic ack);
        logic full;
        logic acc;
        valid_i                 = v;
        register_write_index_i  = idx;
        register_write_enable_i = rwe;
        memory_write_enable_i   = mwe;
        memory_write_size_i     = sz;
        memory_write_address_i  = addr;
        result_i                = data;
        mem_ack_i               = ack;
        full = (q.size() == DEPTH);
        acc  = v & ~full;
        m_idx    = idx;
        m_result = data;
        m_rwe    = acc & rwe;
        if (q.size() != 0 && ack) void'(q.pop_front());
        if (acc && mwe) q.push_back(make_entry(sz, addr, data));
        @(negedge clk_i);
        check_all();
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] data, input logic ack);
        drive(1'b1, 4'd0, 1'b0, 1'b1, sz, addr, data, ack);
    endtask

    task automatic idle(input logic ack);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, ack);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 4 && q.size() != 0; k++) idle(1'b1);
        chk("drain_empty", 32'(empty_o), 32'd1);
    endtask

    initial begin
        vecs[0] = '{2'd2, 32'h0000_1003, 32'hDEAD_BEEF, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111};
        vecs[1] = '{2'd0, 32'h0000_2001, 32'h0000_00AB, 32'h0000_2000, 32'hABAB_ABAB, 4'b0100};
        vecs[2] = '{2'd1, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 32'h1234_1234, 4'b0011};
        vecs[3] = '{2'd0, 32'h0000_3000, 32'hFFFF_FF11, 32'h0000_3000, 32'h1111_1111, 4'b1000};
        vecs[4] = '{2'd0, 32'h0000_3003, 32'h0000_0077, 32'h0000_3000, 32'h7777_7777, 4'b0001};
        vecs[5] = '{2'd1, 32'h0000_4001, 32'h5555_BEEF, 32'h0000_4000, 32'hBEEF_BEEF, 4'b1100};
        vecs[6] = '{2'd3, 32'h0000_5006, 32'h0123_4567, 32'h0000_5004, 32'h0123_4567, 4'b1111};
        vecs[7] = '{2'd0, 32'h0000_6002, 32'h0000_00C3, 32'h0000_6000, 32'hC3C3_C3C3, 4'b0010};

        rst_i                   = 1'b0;
        valid_i                 = 1'b0;
        register_write_index_i  = '0;
        register_write_enable_i = 1'b0;
        memory_write_enable_i   = 1'b0;
        memory_write_size_i     = '0;
        memory_write_address_i  = '0;
        result_i                = '0;
        mem_ack_i               = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check_all();
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_sel",  32'(mem_sel_o), 32'd0);
        rst_i = 1'b1;

        // Asynchronous reset while stores are pending
        store(2'd2, 32'h0000_0100, 32'h1111_1111, 1'b0);
        store(2'd2, 32'h0000_0104, 32'h2222_2222, 1'b0);
        chk("pre_rst_count", 32'(buffer_count_o), 32'd2);
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_req",   32'(mem_req_o),      32'd0);
        chk("async_rst_count", 32'(buffer_count_o), 32'd0);
        chk("async_rst_empty", 32'(empty_o),        32'd1);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        check_all();

        // Table of single stores: head fields one cycle after push, empty after ack
        for (int i = 0; i < 8; i++) begin
            store(vecs[i].size, vecs[i].addr, vecs[i].data, 1'b1);
            chk("vec_req",  32'(mem_req_o),  32'd1);
            chk("vec_addr", mem_addr_o,      vecs[i].exp_addr);
            chk("vec_data", mem_data_o,      vecs[i].exp_data);
            chk("vec_sel",  32'(mem_sel_o),  32'(vecs[i].exp_sel));
            idle(1'b1);
            chk("vec_empty", 32'(empty_o), 32'd1);
        end

        // Fill to full with ack low, fifth store held
        for (int i = 1; i <= 5; i++) begin
            store(2'd2, 32'(i * 16), 32'(i), 1'b0);
            if (i == 4) chk("full_stall", 32'(stall_o), 32'd1);
        end
        chk("full_count", 32'(buffer_count_o), 32'(DEPTH));
        store(2'd2, 32'd80, 32'd5, 1'b1);
        chk("pop_at_full_count", 32'(buffer_count_o), 32'd3);
        chk("stall_drops", 32'(stall_o), 32'd0);
        store(2'd2, 32'd80, 32'd5, 1'b0);
        chk("fifth_accepted", 32'(buffer_count_o), 32'(DEPTH));
        drain();

        // Simultaneous push and pop at count 2, across pointer wraps
        store(2'd2, 32'h100, 32'hA0, 1'b0);
        store(2'd2, 32'h104, 32'hA1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            store(2'(i % 3), 32'h200 + 32'(i * 5), 32'hB0 + 32'(i), 1'b1);
            chk("pushpop_count", 32'(buffer_count_o), 32'd2);
        end
        drain();

        // Register writeback path, unstalled and stalled
        drive(1'b1, 4'd7, 1'b1, 1'b0, 2'd0, 32'd0, 32'h55, 1'b0);
        chk("regwb_we",  32'(register_write_enable_o), 32'd1);
        chk("regwb_idx", 32'(register_write_index_o),  32'd7);
        chk("regwb_res", result_o, 32'h55);
        for (int i = 0; i < DEPTH; i++) store(2'd2, 32'(i * 4), 32'(i), 1'b0);
        chk("regwb_full", 32'(stall_o), 32'd1);
        drive(1'b1, 4'd7, 1'b1, 1'b0, 2'd0, 32'd0, 32'h55, 1'b0);
        chk("regwb_stalled_we", 32'(register_write_enable_o), 32'd0);
        drain();

        // Randomized traffic with varying ack pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                drive($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
                      1'($urandom), 2'($urandom), $urandom, $urandom,
                      $urandom_range(0, 3) < ph);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
